// File: rtl/rram_pulse_seq_pkg.sv
// rram_pkg: shared definitions for the RRAM pulse sequencer.
//   - op_e    : command opcodes as carried on cmd_op
//   - state_e : sequencer FSM states (ST_VERIFY exists only when
//               RRAM_PULSE_VERIFY_EN is defined)
//   - default setup/hold cycle counts
//   - onehot2 : 1-bit select to 2-bit one-hot enable
package rram_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_SET   = 2'd1,
      OP_RESET = 2'd2,
      OP_FORM  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_SAMPLE,
`ifdef RRAM_PULSE_VERIFY_EN
      ST_VERIFY,
`endif
      ST_DONE
   } state_e;

   localparam int SETUP_CYC_DEF = 4;
   localparam int HOLD_CYC_DEF  = 4;

   function automatic logic [1:0] onehot2(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rram_pulse_seq_if.sv
// rram_pulse_seq_if: command/response bus between the register front end
// (master) and the pulse sequencer (slave).
//   cmd_valid/cmd_ready : command handshake, op/row/col/width payload
//   rsp_valid           : one-cycle response strobe with rsp_bit/rsp_err
//   busy                : sequencer is not idle
interface rram_pulse_seq_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             cmd_row;
   logic             cmd_col;
   logic [CNT_W-1:0] cmd_width;
   logic             rsp_valid;
   logic             rsp_bit;
   logic             rsp_err;
   logic             busy;

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_width,
      input  cmd_ready, rsp_valid, rsp_bit, rsp_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_width,
      output cmd_ready, rsp_valid, rsp_bit, rsp_err, busy
   );
endinterface

// File: rtl/rram_pulse_seq_sync2.sv
// rram_sync2: two-flop synchronizer with asynchronous active-low clear.
//   clk, rst_n : clock / async clear
//   d_i        : asynchronous input
//   q_o        : synchronized output
module rram_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/rram_pulse_seq.sv
// rram_pulse_seq: FORM/SET/RESET/READ pulse sequencer for the 1T1R test array.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command/response interface (slave side)
//   wl_en      : one-hot word-line enable
//   bl_en/br_en: one-hot bit-line / source-line drive enables by column
//   re_en      : read-path enable, form_en: forming supply select
//   sense_i    : asynchronous comparator output
// Optional macro RRAM_PULSE_VERIFY_EN adds a write-verify/retry loop and
// the MAX_RETRY parameter; without it rsp_err is tied low.
module rram_pulse_seq
   import rram_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int SETUP_CYC = SETUP_CYC_DEF,
`ifdef RRAM_PULSE_VERIFY_EN
   parameter int MAX_RETRY = 7,
`endif
   parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   rram_pulse_seq_if.slave bus,
   output logic [1:0]     wl_en,
   output logic [1:0]     bl_en,
   output logic [1:0]     br_en,
   output logic           re_en,
   output logic           form_en,
   input  logic           sense_i
);
   state_e           state_q;
   op_e              op_q;
   logic             col_q;
   logic [CNT_W-1:0] width_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       wl_q, bl_q, br_q;
   logic             re_q, form_q;
   logic             rdy_q, busy_q;
   logic             rsp_valid_q, rsp_bit_q;
   logic             smp_q;
   logic             sense_s;

   rram_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (sense_i),
      .q_o   (sense_s)
   );

`ifdef RRAM_PULSE_VERIFY_EN
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   logic [RTY_W-1:0] retry_q;
   logic             err_q;
   logic             vfy_ok;
   // RESET targets the high-resistance state, SET/FORM the low one.
   assign vfy_ok = (sense_s == (op_q != OP_RESET));
`endif

   // All enables are registered so async reset drops them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         col_q       <= 1'b0;
         width_q     <= '0;
         cnt_q       <= '0;
         wl_q        <= 2'b00;
         bl_q        <= 2'b00;
         br_q        <= 2'b00;
         re_q        <= 1'b0;
         form_q      <= 1'b0;
         rdy_q       <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_bit_q   <= 1'b0;
         smp_q       <= 1'b0;
`ifdef RRAM_PULSE_VERIFY_EN
         retry_q     <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q    <= op_e'(bus.cmd_op);
                  col_q   <= bus.cmd_col;
                  width_q <= (bus.cmd_width == '0) ? CNT_W'(1) : bus.cmd_width;
                  wl_q    <= onehot2(bus.cmd_row);
                  cnt_q   <= CNT_W'(SETUP_CYC);
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
`ifdef RRAM_PULSE_VERIFY_EN
                  retry_q <= '0;
                  err_q   <= 1'b0;
`endif
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_q == CNT_W'(1)) begin
                  cnt_q   <= width_q;
                  bl_q    <= (op_q != OP_RESET) ? onehot2(col_q) : 2'b00;
                  br_q    <= (op_q == OP_RESET) ? onehot2(col_q) : 2'b00;
                  re_q    <= (op_q == OP_READ);
                  form_q  <= (op_q == OP_FORM);
                  state_q <= ST_PULSE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_PULSE: begin
               // re_en is left as-is: a READ keeps it through HOLD.
               if (cnt_q == CNT_W'(1)) begin
                  cnt_q   <= CNT_W'(HOLD_CYC);
                  bl_q    <= 2'b00;
                  br_q    <= 2'b00;
                  form_q  <= 1'b0;
                  state_q <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(1)) begin
                  if (op_q == OP_READ) begin
                     smp_q   <= sense_s;
                     state_q <= ST_SAMPLE;
                  end else begin
`ifdef RRAM_PULSE_VERIFY_EN
                     // Internal one-cycle read of the same cell.
                     bl_q    <= onehot2(col_q);
                     re_q    <= 1'b1;
                     state_q <= ST_VERIFY;
`else
                     wl_q        <= 2'b00;
                     rsp_valid_q <= 1'b1;
                     rsp_bit_q   <= 1'b0;
                     state_q     <= ST_DONE;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               wl_q        <= 2'b00;
               re_q        <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_bit_q   <= smp_q;
               state_q     <= ST_DONE;
            end
`ifdef RRAM_PULSE_VERIFY_EN
            ST_VERIFY: begin
               bl_q <= 2'b00;
               re_q <= 1'b0;
               if (vfy_ok || retry_q == RTY_W'(MAX_RETRY)) begin
                  wl_q        <= 2'b00;
                  rsp_valid_q <= 1'b1;
                  rsp_bit_q   <= vfy_ok ? 1'b0 : sense_s;
                  err_q       <= !vfy_ok;
                  state_q     <= ST_DONE;
               end else begin
                  // Retry with WL kept asserted through the new SETUP.
                  retry_q <= retry_q + RTY_W'(1);
                  cnt_q   <= CNT_W'(SETUP_CYC);
                  state_q <= ST_SETUP;
               end
            end
`endif
            ST_DONE: begin
               rdy_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wl_en         = wl_q;
   assign bl_en         = bl_q;
   assign br_en         = br_q;
   assign re_en         = re_q;
   assign form_en       = form_q;
   assign bus.cmd_ready = rdy_q;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_bit   = rsp_bit_q;
`ifdef RRAM_PULSE_VERIFY_EN
   assign bus.rsp_err   = err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_rram_pulse_seq.sv
// Testbench for rram_pulse_seq. Each command's expected per-cycle output
// waveform is generated from the phase rules (setup, pulse, hold, sample,
// done) and compared cycle by cycle at the falling clock edge.
module tb_rram_pulse_seq;
   localparam int CNT_W     = 8;
   localparam int SETUP_CYC = 4;
   localparam int HOLD_CYC  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sense_i = 1'b0;
   logic [1:0] wl_en, bl_en, br_en;
   logic       re_en, form_en;

   int checks = 0;
   int errors = 0;
   logic [10:0] expq[$];

   rram_pulse_seq_if #(.CNT_W(CNT_W)) bus();

   rram_pulse_seq #(
      .CNT_W     (CNT_W),
      .SETUP_CYC (SETUP_CYC),
      .HOLD_CYC  (HOLD_CYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .wl_en   (wl_en),
      .bl_en   (bl_en),
      .br_en   (br_en),
      .re_en   (re_en),
      .form_en (form_en),
      .sense_i (sense_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // {wl[2], bl[2], br[2], re, form, rsp_valid, busy, cmd_ready}
   function automatic logic [10:0] pk(input logic [1:0] wl, input logic [1:0] bl,
                                      input logic [1:0] br, input logic re,
                                      input logic form, input logic rv,
                                      input logic bsy, input logic rdy);
      return {wl, bl, br, re, form, rv, bsy, rdy};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {wl_en, bl_en, br_en, re_en, form_en, bus.rsp_valid, bus.busy, bus.cmd_ready};
   endfunction

   // Safety invariants on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("inv_bl_br", 16'((bl_en != 2'b00) && (br_en != 2'b00)), 16'd0);
         chk("inv_wl_onehot", 16'($onehot0(wl_en)), 16'd1);
         chk("inv_pulse_wl", 16'(((bl_en | br_en) != 2'b00 || re_en || form_en) && wl_en == 2'b00), 16'd0);
      end
   end

   task automatic build(input int op, input int row, input int col, input int w);
      logic [1:0] wv, cv;
      int pw;
      wv = (row == 1) ? 2'b10 : 2'b01;
      cv = (col == 1) ? 2'b10 : 2'b01;
      pw = (w == 0) ? 1 : w;
      expq.delete();
      repeat (SETUP_CYC) expq.push_back(pk(wv, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      repeat (pw) expq.push_back(pk(wv, (op != 2) ? cv : 2'b00, (op == 2) ? cv : 2'b00,
                                    op == 0, op == 3, 1'b0, 1'b1, 1'b0));
      repeat (HOLD_CYC) expq.push_back(pk(wv, 2'b00, 2'b00, op == 0, 1'b0, 1'b0, 1'b1, 1'b0));
      if (op == 0) expq.push_back(pk(wv, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef RRAM_PULSE_VERIFY_EN
      else expq.push_back(pk(wv, cv, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
`endif
      expq.push_back(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      expq.push_back(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic scramble();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_row   = 1'($urandom);
      bus.cmd_col   = 1'($urandom);
      bus.cmd_width = 8'($urandom);
   endtask

   // Waits for ready (bounded), presents the command, returns #1 after accept.
   task automatic drive_cmd(input int op, input int row, input int col, input int w, input logic s);
      int n;
      n = 0;
      @(negedge clk);
      sense_i = s;
      repeat (3) @(negedge clk);
      while (bus.cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_cmd", 16'(bus.cmd_ready), 16'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'(op);
      bus.cmd_row   = 1'(row);
      bus.cmd_col   = 1'(col);
      bus.cmd_width = 8'(w);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cmd(input int op, input int row, input int col, input int w, input logic s);
      logic [10:0] e;
      build(op, row, col, w);
      for (int i = 0; i < expq.size(); i++) begin
         e = expq[i];
         @(negedge clk);
         chk($sformatf("wave_op%0d_w%0d_c%0d", op, w, i), 16'(obs_vec()), 16'(e));
         if (e[2]) begin
            chk("rsp_bit", 16'(bus.rsp_bit), 16'((op == 0) ? s : 1'b0));
            chk("rsp_err", 16'(bus.rsp_err), 16'd0);
         end
      end
   endtask

   initial begin
      int op, row, col, w;
      logic s;
      scramble();
      repeat (3) @(negedge clk);
      chk("reset_vec", 16'(obs_vec()), 16'(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
      chk("reset_rsp", 16'({bus.rsp_bit, bus.rsp_err}), 16'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_vec", 16'(obs_vec()), 16'(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));

      // SET row1 col0 width 3
      drive_cmd(1, 1, 0, 3, 1'b1); scramble(); expect_cmd(1, 1, 0, 3, 1'b1);
      // READ row0 col1 width 0, sensed 1 then 0
      drive_cmd(0, 0, 1, 0, 1'b1); scramble(); expect_cmd(0, 0, 1, 0, 1'b1);
      drive_cmd(0, 0, 1, 0, 1'b0); scramble(); expect_cmd(0, 0, 1, 0, 1'b0);
      // FORM row0 col0 width 5
      drive_cmd(3, 0, 0, 5, 1'b1); scramble(); expect_cmd(3, 0, 0, 5, 1'b1);

      // RESET aborted by reset two cycles into the pulse
      drive_cmd(2, 1, 1, 6, 1'b0); scramble();
      repeat (SETUP_CYC + 2) @(negedge clk);
      chk("abort_in_pulse", 16'(br_en), 16'h2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_vec", 16'(obs_vec()), 16'(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("after_abort", 16'(obs_vec()), 16'(pk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
      end

      // cmd_valid held during a busy RESET: second command waits for IDLE
      drive_cmd(2, 0, 0, 2, 1'b0);
      bus.cmd_op = 2'd0; bus.cmd_row = 1'b1; bus.cmd_col = 1'b0; bus.cmd_width = 8'd1;
      expect_cmd(2, 0, 0, 2, 1'b0);
      @(posedge clk);
      #1 scramble();
      expect_cmd(0, 1, 0, 1, 1'b0);

      // Randomized commands
      for (int k = 0; k < 8; k++) begin
         op  = int'($urandom_range(0, 3));
         row = int'($urandom_range(0, 1));
         col = int'($urandom_range(0, 1));
         w   = int'($urandom_range(0, 6));
         s   = (op == 0) ? 1'($urandom) : (op != 2);
         drive_cmd(op, row, col, w, s); scramble(); expect_cmd(op, row, col, w, s);
      end

`ifdef RRAM_PULSE_VERIFY_EN
      // SET with verify: pass on the third verify, then a stuck cell
      for (int stuck = 0; stuck < 2; stuck++) begin
         int pulses, vfy, n;
         logic prev_p, done;
         pulses = 0; vfy = 0; n = 0; prev_p = 1'b0; done = 1'b0;
         drive_cmd(1, 0, 1, 2, 1'b0); scramble();
         while (!done && n < 600) begin
            @(negedge clk);
            n++;
            if (bl_en != 2'b00 && !re_en && !prev_p) pulses++;
            prev_p = (bl_en != 2'b00 && !re_en);
            if (re_en) vfy++;
            if (stuck == 0 && vfy == 2) sense_i = 1'b1;
            if (bus.rsp_valid) begin
               done = 1'b1;
               chk("verify_err", 16'(bus.rsp_err), 16'(stuck));
               chk("verify_pulses", 16'(pulses), (stuck == 1) ? 16'd8 : 16'd3);
               if (stuck == 1) chk("verify_bit", 16'(bus.rsp_bit), 16'd0);
            end
         end
         chk("verify_timeout", 16'(done), 16'd1);
         @(negedge clk);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
